// File: rtl/tcam_srl_pkg.sv
// tcam_pkg: shared definitions for the tcam_srl ternary CAM.
//   state_t      - write/erase sequencer states
//   num_slices() - SRL slices needed to cover a key of a given width
//   srl_depth()  - taps per SRL (one per possible slice value)
package tcam_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        WRITE = 2'd2
    } state_t;

    function automatic int unsigned num_slices(input int unsigned data_width,
                                               input int unsigned slice_width);
        return (data_width + slice_width - 1) / slice_width;
    endfunction

    function automatic int unsigned srl_depth(input int unsigned slice_width);
        return 32'd1 << slice_width;
    endfunction

endpackage

// File: rtl/tcam_srl_priority_encoder.sv
// priority_encoder: lowest set request bit wins.
//   req   - request vector
//   grant - one-hot copy of the winning bit (0 when none)
//   index - index of the winning bit (0 when none)
//   any   - at least one request bit set
module priority_encoder #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned INDEX_WIDTH = 5
) (
    input  logic [WIDTH-1:0]       req,
    output logic [WIDTH-1:0]       grant,
    output logic [INDEX_WIDTH-1:0] index,
    output logic                   any
);

    always_comb begin
        grant = '0;
        index = '0;
        any   = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (req[i] && !any) begin
                any      = 1'b1;
                grant[i] = 1'b1;
                index    = INDEX_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/tcam_srl.sv
// tcam_srl: ternary CAM built from per-(entry, slice) shift registers.
//   clk, rst                    - clock, synchronous active-high reset
//   write_addr/data/mask/delete - entry update; mask 1 = care bit
//   write_enable, write_busy    - update request / sequencer busy
//   compare_data, compare_valid - search request
//   match_many, match_single,
//   match_addr, match           - search result, lowest index wins
//   match_valid                 - result of the request 2 cycles earlier
module tcam_srl
    import tcam_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned ADDR_WIDTH  = 5,
    parameter int unsigned SLICE_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_WIDTH-1:0]    write_addr,
    input  logic [DATA_WIDTH-1:0]    write_data,
    input  logic [DATA_WIDTH-1:0]    write_mask,
    input  logic                     write_delete,
    input  logic                     write_enable,
    output logic                     write_busy,
    input  logic [DATA_WIDTH-1:0]    compare_data,
    input  logic                     compare_valid,
    output logic [2**ADDR_WIDTH-1:0] match_many,
    output logic [2**ADDR_WIDTH-1:0] match_single,
    output logic [ADDR_WIDTH-1:0]    match_addr,
    output logic                     match,
    output logic                     match_valid
);

    localparam int unsigned NS      = num_slices(DATA_WIDTH, SLICE_WIDTH);
    localparam int unsigned DEPTH   = srl_depth(SLICE_WIDTH);
    localparam int unsigned ENTRIES = 2**ADDR_WIDTH;
    localparam int unsigned PW      = NS * SLICE_WIDTH;

    state_t                 state, state_next;
    logic [SLICE_WIDTH-1:0] cnt, cnt_next;

    logic [ADDR_WIDTH-1:0]  wr_addr;
    logic [PW-1:0]          wr_data;
    logic [PW-1:0]          wr_mask;
    logic                   wr_delete;
    logic [NS-1:0]          wr_bits;

    logic [DEPTH-1:0]       srl [ENTRIES][NS];

    logic [PW-1:0]          cmp_pad;
    logic                   valid1;
    logic [NS-1:0]          hits1 [ENTRIES];
    logic [ENTRIES-1:0]     many2;
    logic [ENTRIES-1:0]     single2;
    logic [ADDR_WIDTH-1:0]  addr2;
    logic                   any2;

    // ---------------- sequencer ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '1;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            CLEAR, WRITE: begin
                cnt_next = cnt - 1'b1;
                if (cnt == '0) state_next = IDLE;
            end
            IDLE: begin
                if (write_enable) begin
                    state_next = WRITE;
                    cnt_next   = '1;
                end
            end
            default: state_next = CLEAR;
        endcase
    end

    always_comb begin
        write_busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst && state == IDLE && write_enable) begin
            wr_addr   <= write_addr;
            wr_data   <= PW'(write_data);
            wr_mask   <= PW'(write_mask);
            wr_delete <= write_delete;
        end
    end

    // Bit for slice value v = cnt; shifted highest value first so tap v ends up holding v.
    always_comb begin
        wr_bits = '0;
        for (int unsigned s = 0; s < NS; s++) begin
            wr_bits[s] = !wr_delete &&
                (((cnt ^ wr_data[s*SLICE_WIDTH +: SLICE_WIDTH]) &
                  wr_mask[s*SLICE_WIDTH +: SLICE_WIDTH]) == '0);
        end
    end

    // ---------------- SRL storage ----------------
    always_ff @(posedge clk) begin
        for (int unsigned e = 0; e < ENTRIES; e++) begin
            for (int unsigned s = 0; s < NS; s++) begin
                if (state == CLEAR) begin
                    srl[e][s] <= {srl[e][s][DEPTH-2:0], 1'b0};
                end else if (state == WRITE && wr_addr == ADDR_WIDTH'(e)) begin
                    srl[e][s] <= {srl[e][s][DEPTH-2:0], wr_bits[s]};
                end
            end
        end
    end

    // ---------------- lookup stage 1 ----------------
    always_comb begin
        cmp_pad = PW'(compare_data);
    end

    // Entries whose SRLs are mid-shift hold a mix of old and new taps, so they are forced to miss.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid1 <= 1'b0;
            hits1  <= '{default: '0};
        end else begin
            valid1 <= compare_valid;
            for (int unsigned e = 0; e < ENTRIES; e++) begin
                for (int unsigned s = 0; s < NS; s++) begin
                    hits1[e][s] <= srl[e][s][cmp_pad[s*SLICE_WIDTH +: SLICE_WIDTH]] &&
                                   !(state == CLEAR ||
                                     (state == WRITE && wr_addr == ADDR_WIDTH'(e)));
                end
            end
        end
    end

    // ---------------- lookup stage 2 ----------------
    always_comb begin
        many2 = '0;
        for (int unsigned e = 0; e < ENTRIES; e++) begin
            many2[e] = &hits1[e];
        end
    end

    priority_encoder #(
        .WIDTH       (ENTRIES),
        .INDEX_WIDTH (ADDR_WIDTH)
    ) u_prio (
        .req   (many2),
        .grant (single2),
        .index (addr2),
        .any   (any2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            match_valid  <= 1'b0;
            match_many   <= '0;
            match_single <= '0;
            match_addr   <= '0;
            match        <= 1'b0;
        end else begin
            match_valid <= valid1;
            if (valid1) begin
                match_many   <= many2;
                match_single <= single2;
                match_addr   <= addr2;
                match        <= any2;
            end
        end
    end

endmodule

// File: tb/tb_tcam_srl.sv
// tb_tcam_srl: directed stimulus with a scoreboard queue for tcam_srl
// (DATA_WIDTH=64, ADDR_WIDTH=5, SLICE_WIDTH=4). Inputs change on the
// falling edge; results are popped and compared on the falling edge.
module tb_tcam_srl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  write_addr;
    logic [63:0] write_data;
    logic [63:0] write_mask;
    logic        write_delete;
    logic        write_enable;
    logic        write_busy;
    logic [63:0] compare_data;
    logic        compare_valid;
    logic [31:0] match_many;
    logic [31:0] match_single;
    logic [4:0]  match_addr;
    logic        match;
    logic        match_valid;

    tcam_srl #(
        .DATA_WIDTH  (64),
        .ADDR_WIDTH  (5),
        .SLICE_WIDTH (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .write_addr    (write_addr),
        .write_data    (write_data),
        .write_mask    (write_mask),
        .write_delete  (write_delete),
        .write_enable  (write_enable),
        .write_busy    (write_busy),
        .compare_data  (compare_data),
        .compare_valid (compare_valid),
        .match_many    (match_many),
        .match_single  (match_single),
        .match_addr    (match_addr),
        .match         (match),
        .match_valid   (match_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] many;
        logic [4:0]  addr;
        int unsigned cyc;
    } exp_t;

    exp_t        sb [$];
    exp_t        e;
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          n;

    localparam logic [63:0] KEY_A  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] KEY_T  = 64'hAB12_3456_7800_0000;
    localparam logic [63:0] KEY_N  = 64'hAC00_0000_0000_0000;
    localparam logic [63:0] KEY_5  = 64'h5555_5555_5555_5555;
    localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every presented result is matched against the oldest expectation.
    always @(negedge clk) begin
        if (match_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got match_valid=1 expected no result (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("latency",      64'(cyc),          64'(e.cyc + 2));
                chk("match_many",   64'(match_many),   64'(e.many));
                chk("match_single", 64'(match_single),
                    (e.many != 0) ? (64'd1 << e.addr) : 64'd0);
                chk("match_addr",   64'(match_addr),   (e.many != 0) ? 64'(e.addr) : 64'd0);
                chk("match",        64'(match),        64'(e.many != 0));
            end
        end
    end

    // Issue one compare this cycle; returns on the next falling edge.
    task automatic cmp(input logic [63:0] key, input logic [31:0] many, input logic [4:0] addr);
        exp_t x;
        compare_data  = key;
        compare_valid = 1'b1;
        x.many = many;
        x.addr = addr;
        x.cyc  = cyc;
        sb.push_back(x);
        @(negedge clk);
        compare_valid = 1'b0;
    endtask

    // Count busy cycles, optionally issuing a compare each cycle and
    // pulsing a write request (to be ignored) in busy cycle 3.
    task automatic busy_wait(input logic do_cmp, input logic [63:0] key,
                             input logic [31:0] many, input logic [4:0] addr,
                             input logic pulse, output int cnt);
        cnt = 0;
        while (write_busy === 1'b1 && cnt < 64) begin
            cnt++;
            if (pulse && cnt == 3) begin
                write_addr   = 5'd1;
                write_data   = '0;
                write_mask   = '0;
                write_delete = 1'b0;
                write_enable = 1'b1;
            end else begin
                write_enable = 1'b0;
            end
            if (do_cmp) cmp(key, many, addr);
            else @(negedge clk);
        end
        write_enable = 1'b0;
    endtask

    task automatic wr(input logic [4:0] addr, input logic [63:0] data,
                      input logic [63:0] mask, input logic del);
        write_addr   = addr;
        write_data   = data;
        write_mask   = mask;
        write_delete = del;
        write_enable = 1'b1;
        @(negedge clk);
        write_enable = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        write_addr    = '0;
        write_data    = '0;
        write_mask    = '0;
        write_delete  = 1'b0;
        write_enable  = 1'b0;
        compare_data  = '0;
        compare_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state, then the clear sequence with lookups during it.
        chk("reset_match_valid", 64'(match_valid), 64'd0);
        chk("reset_match_many",  64'(match_many),  64'd0);
        chk("reset_match",       64'(match),       64'd0);
        chk("reset_busy",        64'(write_busy),  64'd1);
        busy_wait(1'b1, KEY_A, 32'h0, 5'd0, 1'b0, n);
        chk("clear_busy_cycles", 64'(n), 64'd16);
        cmp(64'd0, 32'h0, 5'd0);
        cmp(ONES,  32'h0, 5'd0);

        // Exact entry.
        wr(5'd3, KEY_A, ONES, 1'b0);
        busy_wait(1'b0, 64'd0, 32'h0, 5'd0, 1'b0, n);
        chk("write3_busy_cycles", 64'(n), 64'd16);
        cmp(KEY_A,         32'h0000_0008, 5'd3);
        cmp(KEY_A ^ 64'd1, 32'h0,         5'd0);

        // Ternary entry: only the top byte cares.
        wr(5'd5, 64'hAB00_0000_0000_0000, 64'hFF00_0000_0000_0000, 1'b0);
        busy_wait(1'b0, 64'd0, 32'h0, 5'd0, 1'b0, n);
        chk("write5_busy_cycles", 64'(n), 64'd16);
        cmp(KEY_T, 32'h0000_0020, 5'd5);
        cmp(KEY_N, 32'h0,         5'd0);
        cmp(KEY_A, 32'h0000_0008, 5'd3);

        // Two all-don't-care entries: lowest index wins.
        wr(5'd7, 64'd0, 64'd0, 1'b0);
        busy_wait(1'b0, 64'd0, 32'h0, 5'd0, 1'b0, n);
        wr(5'd2, 64'd0, 64'd0, 1'b0);
        busy_wait(1'b0, 64'd0, 32'h0, 5'd0, 1'b0, n);
        cmp(KEY_5, 32'h0000_0084, 5'd2);
        cmp(KEY_A, 32'h0000_008C, 5'd2);
        cmp(KEY_T, 32'h0000_00A4, 5'd2);

        // Delete entry 2.
        wr(5'd2, ONES, ONES, 1'b1);
        busy_wait(1'b0, 64'd0, 32'h0, 5'd0, 1'b0, n);
        chk("delete_busy_cycles", 64'(n), 64'd16);
        cmp(KEY_5, 32'h0000_0080, 5'd7);

        // Rewrite entry 7 while looking up every cycle: 7 is masked out,
        // entry 3 still hits. A write request mid-busy must be dropped.
        wr(5'd7, KEY_A, ONES, 1'b0);
        busy_wait(1'b1, KEY_A, 32'h0000_0008, 5'd3, 1'b1, n);
        chk("rewrite7_busy_cycles", 64'(n), 64'd16);
        cmp(KEY_A, 32'h0000_0088, 5'd3);
        cmp(KEY_5, 32'h0,         5'd0);
        cmp(KEY_T, 32'h0000_0020, 5'd5);

        // Reset in the sixth busy cycle of a write.
        repeat (3) @(negedge clk);
        wr(5'd9, 64'd0, 64'd0, 1'b0);
        repeat (5) @(negedge clk);
        chk("midwrite_busy", 64'(write_busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        busy_wait(1'b1, KEY_A, 32'h0, 5'd0, 1'b0, n);
        chk("reclear_busy_cycles", 64'(n), 64'd16);
        cmp(KEY_A, 32'h0, 5'd0);
        cmp(KEY_5, 32'h0, 5'd0);
        cmp(KEY_T, 32'h0, 5'd0);

        // Drain the scoreboard with a bounded wait.
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tcam_srl.md
Name: tcam_srl

Overview:
- Ternary CAM, successor to the SRL binary CAM.
- Each entry stores data plus a per-bit care mask.
- Lookup is pipelined with a compare_valid/match_valid qualifier and a fixed 2-cycle latency.
- Reset actively clears all entries via a sequenced erase.
- Sits in the same lookup path as the binary CAM (flow/ACL tables) and reuses its write/match port semantics.

Parameters:
- DATA_WIDTH, 64: search key width; need not be a multiple of SLICE_WIDTH.
- ADDR_WIDTH, 5: log2 of entry count.
- SLICE_WIDTH, 4: key bits per SRL slice; write/erase takes 2**SLICE_WIDTH cycles.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- write_addr  in  ADDR_WIDTH  entry to write/delete
- write_data  in  DATA_WIDTH  key value
- write_mask  in  DATA_WIDTH  1 = care bit, 0 = don't-care
- write_delete  in  1  1 = invalidate entry (data/mask ignored)
- write_enable  in  1  request; accepted only when write_busy=0
- write_busy  out  1  write, delete or reset-clear in progress
- compare_data  in  DATA_WIDTH  search key
- compare_valid  in  1  search request qualifier
- match_many  out  2**ADDR_WIDTH  all matching entries
- match_single  out  2**ADDR_WIDTH  one-hot, lowest matching index
- match_addr  out  ADDR_WIDTH  lowest matching index
- match  out  1  any entry matched
- match_valid  out  1  outputs above correspond to a request 2 cycles earlier

Behaviour:
- Storage: NS = ceil(DATA_WIDTH/SLICE_WIDTH) slices. Each (entry, slice) pair is a 2**SLICE_WIDTH x 1 shift register, addressed by the key slice.
- Padding: key/compare padded with 0 and mask padded with 0 up to NS*SLICE_WIDTH.
- Bit stored for slice value v: not delete AND ((v ^ data_slice) & mask_slice) == 0.
- FSM states: CLEAR, IDLE, WRITE. A 2**SLICE_WIDTH-count down-counter cnt drives CLEAR and WRITE.
- Reset behaviour: rst (any state, including mid-write) -> CLEAR, cnt = 2**SLICE_WIDTH-1, write_busy=1.
- Reset values of outputs: match_many/match_single/match_addr/match/match_valid = 0.
- CLEAR: shifts 0 into every SRL of every entry each cycle. At cnt==0 -> IDLE on the next cycle. Total 2**SLICE_WIDTH busy cycles after rst deasserts.
- IDLE: write_busy=0. write_enable=1 latches addr/data/mask/delete -> WRITE with cnt = 2**SLICE_WIDTH-1. write_busy=1 from the next cycle.
- WRITE: each cycle shifts bit(v=cnt) into every slice SRL of the latched entry only; cnt decrements. At cnt==0 -> IDLE. Writes take exactly 2**SLICE_WIDTH busy cycles.
- Shift order: highest value first, so SRL tap v holds value v.
- write_enable while busy is ignored (not queued).
- Lookup stage 1: per entry, read each slice SRL at the compare slice value; register the per-slice bits and the valid flag.
- Lookup stage 2: AND-reduce per entry into match_many; priority-encode into match_single, match_addr and match; register.
- Latency: outputs valid with match_valid exactly 2 cycles after compare_valid. Fully pipelined, one lookup per cycle.
- Outputs when match_valid=0: hold their previous values.
- Lookups are accepted during write_busy. The entry under write/erase is forced non-matching in stage 1; all other entries match normally. During CLEAR all entries report no match.
- After a write completes (write_busy falls at cycle N), a compare issued at cycle N sees the new contents.
- No match: match=0, match_addr=0, match_single=0.
- Overlapping entries: all matching bits are set in match_many; the lowest index wins match_addr.

Decomposition:
- Package tcam_pkg:
  - NS function/constant
  - FSM state encoding (CLEAR, IDLE, WRITE)
  - SRL depth constant 2**SLICE_WIDTH
- Sub-module priority_encoder (WIDTH=2**ADDR_WIDTH, lowest index highest priority), used in stage 2.
- SRL arrays are inferred inline; no separate module.

Test Plan:
- Reset clear: rst 1 cycle -> write_busy=1 for exactly 16 cycles (SLICE_WIDTH=4). Any compare meanwhile and afterwards returns match=0, match_valid 2 cycles after compare_valid.
- Exact write then hit: write addr 3, data 0x0123456789ABCDEF, mask all-ones -> busy 16 cycles; compare same key -> match=1, match_addr=3, match_single=0x8, match_many=0x8. Compare key^1 -> match=0.
- Ternary: addr 5, data 0xAB00..00, mask 0xFF00..00 -> compare 0xAB12345678000000 matches addr 5; 0xAC00..00 does not.
- Priority: addr 7 and addr 2 both all-don't-care -> any key gives match_many=0x84, match_addr=2, match_single=0x04. Delete addr 2 -> match_addr=7.
- Write masking and back-to-back: while addr 7 is rewritten, per-cycle compares show bit 7 = 0 and other bits unchanged. write_enable pulses during busy are ignored. Throughput = 1 result/cycle.
- Reset mid-write: rst at cycle 6 of a write -> CLEAR runs 16 cycles, then all entries miss, including entries written earlier.
